nist_health_engine: RTL and testbench

NIST_HEALTH_ENGINE -- requirements
Module: nist_health_engine

---
 rtl/nist_health_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_nist_health_engine.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nist_health_engine.sv
`default_nettype none
// ============================================================================
//  Module   : nist_health_engine
//  Purpose  : Online health check for a raw random bit stream. It collects
//             N = 2^LOG2_N accepted bits. It then evaluates three tests on
//             that sequence:
//               - monobit      : |S| > MONO_LIM, where S = 2*ones - N
//               - block freq   : sum over blocks of (2c - M)^2 > BF_LIM
//               - runs         : |S| > PRE_LIM, or V outside [RUNS_LO, RUNS_HI]
//             In continuous mode the engine restarts collection straight
//             after evaluation. In single-shot mode it waits for start.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             start              - begin one sequence (single-shot mode only)
//             bit_valid, bit_in  - qualified input bit stream
//             busy               - collecting or evaluating
//             done               - one-cycle pulse after the result registers load
//             err_mono/bfreq/runs- per-test fail flags of the last sequence
//             err_sticky         - OR of every fail since reset
//             ones_cnt, runs_cnt - ones count / run count of the last sequence
//  Revision : 1.0 - initial release
// ============================================================================
module nist_health_engine #(
    parameter int unsigned LOG2_N     = 7,
    parameter int unsigned LOG2_M     = 3,
    parameter int unsigned MONO_LIM   = 29,
    parameter int unsigned PRE_LIM    = 44,
    parameter int unsigned BF_LIM     = 256,
    parameter int unsigned RUNS_LO    = 48,
    parameter int unsigned RUNS_HI    = 80,
    parameter bit          CONTINUOUS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              busy,
    output logic              done,
    output logic              err_mono,
    output logic              err_bfreq,
    output logic              err_runs,
    output logic              err_sticky,
    output logic [LOG2_N:0]   ones_cnt,
    output logic [LOG2_N:0]   runs_cnt
);

    localparam int unsigned c_N     = 2 ** LOG2_N;
    localparam int unsigned c_M     = 2 ** LOG2_M;
    localparam int          c_CNT_W = LOG2_N + 1;
    localparam int          c_BLK_W = LOG2_M + 1;
    localparam int          c_DEV_W = LOG2_M + 2;
    localparam int          c_ACC_W = LOG2_N + LOG2_M + 1;
    localparam int          c_S_W   = LOG2_N + 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EVAL    = 2'd2
    } state_t;

    localparam state_t c_RST_STATE = CONTINUOUS ? ST_COLLECT : ST_IDLE;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_accept;
    logic                  w_eval;

    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [c_CNT_W-1:0]    r_ones;
    logic [c_CNT_W-1:0]    r_runs;
    logic [c_BLK_W-1:0]    r_blk;
    logic [c_ACC_W-1:0]    r_acc;
    logic                  r_prev;

    logic                  r_eval_q;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_err_mono;
    logic                  r_err_bfreq;
    logic                  r_err_runs;
    logic                  r_err_sticky;
    logic [c_CNT_W-1:0]    r_ones_cnt;
    logic [c_CNT_W-1:0]    r_runs_cnt;

    logic                  w_last_bit;
    logic                  w_blk_end;
    logic [c_BLK_W-1:0]    w_blk_new;
    logic [c_DEV_W-1:0]    w_c2;
    logic [c_DEV_W-1:0]    w_dev;
    logic [c_ACC_W-1:0]    w_sq;
    logic signed [c_S_W-1:0] w_s;
    logic [c_S_W-1:0]      w_s_abs;
    logic                  w_fail_mono;
    logic                  w_fail_bfreq;
    logic                  w_fail_runs;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_RST_STATE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_eval       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                w_accept = bit_valid;
                if (bit_valid && w_last_bit) begin
                    w_state_next = ST_EVAL;
                end
            end
            ST_EVAL: begin
                // Single evaluation cycle; any bit presented now is dropped.
                w_eval       = 1'b1;
                w_state_next = CONTINUOUS ? ST_COLLECT : ST_IDLE;
            end
            default: begin
                w_state_next = c_RST_STATE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-bit datapath arithmetic
    // ------------------------------------------------------------------
    // r_bit_cnt holds the index of the bit being accepted this cycle.
    assign w_last_bit = (r_bit_cnt == c_CNT_W'(c_N - 1));
    assign w_blk_end  = ((r_bit_cnt & c_CNT_W'(c_M - 1)) == c_CNT_W'(c_M - 1));
    assign w_blk_new  = r_blk + c_BLK_W'(bit_in);

    // |2c - M| lies in 0..M. Its square is at most M^2, and N/M blocks sum
    // to at most N*M, so the accumulator width cannot overflow.
    assign w_c2  = {w_blk_new, 1'b0};
    assign w_dev = (w_c2 >= c_DEV_W'(c_M)) ? (w_c2 - c_DEV_W'(c_M))
                                           : (c_DEV_W'(c_M) - w_c2);
    assign w_sq  = c_ACC_W'(w_dev) * c_ACC_W'(w_dev);

    // S = 2*ones - N lies in [-N, N]. That range fits the signed width.
    assign w_s     = $signed({r_ones, 1'b0} - c_S_W'(c_N));
    assign w_s_abs = w_s[c_S_W-1] ? $unsigned(-w_s) : $unsigned(w_s);

    assign w_fail_mono  = (32'(w_s_abs) > MONO_LIM);
    assign w_fail_bfreq = (64'(r_acc) > 64'(BF_LIM));
    assign w_fail_runs  = (32'(w_s_abs) > PRE_LIM)
                        || (32'(r_runs) < RUNS_LO)
                        || (32'(r_runs) > RUNS_HI);

    // ------------------------------------------------------------------
    // Working counters and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt    <= '0;
            r_ones       <= '0;
            r_runs       <= '0;
            r_blk        <= '0;
            r_acc        <= '0;
            r_prev       <= 1'b0;
            r_eval_q     <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_err_mono   <= 1'b0;
            r_err_bfreq  <= 1'b0;
            r_err_runs   <= 1'b0;
            r_err_sticky <= 1'b0;
            r_ones_cnt   <= '0;
            r_runs_cnt   <= '0;
        end else begin
            if (w_eval) begin
                r_err_mono   <= w_fail_mono;
                r_err_bfreq  <= w_fail_bfreq;
                r_err_runs   <= w_fail_runs;
                r_err_sticky <= r_err_sticky | w_fail_mono | w_fail_bfreq | w_fail_runs;
                r_ones_cnt   <= r_ones;
                r_runs_cnt   <= r_runs;
                // Clearing here leaves a clean slate for both restart paths.
                r_bit_cnt    <= '0;
                r_ones       <= '0;
                r_runs       <= '0;
                r_blk        <= '0;
                r_acc        <= '0;
                r_prev       <= 1'b0;
            end else if (w_accept) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_ones    <= r_ones + c_CNT_W'(bit_in);
                if (w_blk_end) begin
                    r_acc <= r_acc + w_sq;
                    r_blk <= '0;
                end else begin
                    r_blk <= w_blk_new;
                end
                if (r_bit_cnt == '0) begin
                    r_runs <= c_CNT_W'(1);
                end else if (bit_in != r_prev) begin
                    r_runs <= r_runs + 1'b1;
                end
                r_prev <= bit_in;
            end
            // done trails the result load by one cycle. It therefore lands two
            // edges after the edge that accepts the final bit.
            r_eval_q <= w_eval;
            r_done   <= r_eval_q;
            r_busy   <= (w_state_next != ST_IDLE);
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err_mono   = r_err_mono;
    assign err_bfreq  = r_err_bfreq;
    assign err_runs   = r_err_runs;
    assign err_sticky = r_err_sticky;
    assign ones_cnt   = r_ones_cnt;
    assign runs_cnt   = r_runs_cnt;

endmodule
`default_nettype wire

// File: tb/tb_nist_health_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nist_health_engine
//  Purpose  : Directed bench for nist_health_engine at default N=128, M=8.
//             It uses one continuous instance and one single-shot instance.
//             Expected results come from a behavioural model of the tests
//             and are queued when each sequence ends. They are compared when
//             done pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nist_health_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       c_start, c_valid, c_bit;
    logic       s_start, s_valid, s_bit;
    logic       c_busy, c_done, c_mono, c_bfreq, c_runs, c_sticky;
    logic       s_busy, s_done, s_mono, s_bfreq, s_runs, s_sticky;
    logic [7:0] c_ones, c_runs_cnt, s_ones, s_runs_cnt;

    nist_health_engine #(.CONTINUOUS(1'b1)) dut_c (
        .clk(clk), .rst(rst), .start(c_start), .bit_valid(c_valid), .bit_in(c_bit),
        .busy(c_busy), .done(c_done), .err_mono(c_mono), .err_bfreq(c_bfreq),
        .err_runs(c_runs), .err_sticky(c_sticky), .ones_cnt(c_ones), .runs_cnt(c_runs_cnt)
    );

    nist_health_engine #(.CONTINUOUS(1'b0)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .bit_valid(s_valid), .bit_in(s_bit),
        .busy(s_busy), .done(s_done), .err_mono(s_mono), .err_bfreq(s_bfreq),
        .err_runs(s_runs), .err_sticky(s_sticky), .ones_cnt(s_ones), .runs_cnt(s_runs_cnt)
    );

    typedef struct {
        logic [7:0] ones;
        logic [7:0] runs;
        logic       m;
        logic       b;
        logic       r;
        logic       sticky;
        int         edge_n;
    } exp_t;

    exp_t q_c[$];
    exp_t q_s[$];
    logic stk_c, stk_s;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic pat(input int kind, input int i);
        case (kind)
            0:       return 1'b0;                // all zeros
            1:       return ((i % 4) >= 2);      // 0011 repeated
            2:       return ((i % 2) == 1);      // 0101 alternating
            default: return (((i / 8) % 2) == 1);// 8 zeros, 8 ones
        endcase
    endfunction

    // Reference evaluation of one 128-bit sequence, with the default limits.
    function automatic exp_t model(input logic [127:0] bv, input logic sticky_in);
        exp_t e;
        int ones = 0;
        int runs = 1;
        int acc  = 0;
        int s, sa, c;
        for (int i = 0; i < 128; i++) begin
            ones += int'(bv[i]);
            if (i > 0 && bv[i] != bv[i-1]) runs++;
        end
        for (int b = 0; b < 16; b++) begin
            c = 0;
            for (int j = 0; j < 8; j++) c += int'(bv[b*8+j]);
            acc += (2*c - 8) * (2*c - 8);
        end
        s  = 2*ones - 128;
        sa = (s < 0) ? -s : s;
        e.ones   = 8'(ones);
        e.runs   = 8'(runs);
        e.m      = (sa > 29);
        e.b      = (acc > 256);
        e.r      = (sa > 44) || (runs < 48) || (runs > 80);
        e.sticky = sticky_in | e.m | e.b | e.r;
        e.edge_n = 0;
        return e;
    endfunction

    task automatic set_in(input bit sd, input logic v, input logic b, input logic st);
        if (sd) begin
            s_valid = v; s_bit = b; s_start = st;
        end else begin
            c_valid = v; c_bit = b; c_start = st;
        end
    endtask

    // Feed nbits of pattern 'kind'. With gap set, each valid bit is preceded
    // by an invalid cycle that carries the inverted bit.
    task automatic feed(input bit sd, input int kind, input bit gap, input int nbits,
                        input bit push, input int start_at);
        logic [127:0] bv;
        int   last;
        exp_t e;
        last = 0;
        for (int i = 0; i < 128; i++) bv[i] = pat(kind, i);
        for (int i = 0; i < nbits; i++) begin
            if (gap) begin
                @(negedge clk);
                set_in(sd, 1'b0, ~bv[i], 1'b0);
            end
            @(negedge clk);
            set_in(sd, 1'b1, bv[i], (i == start_at));
            last = cyc + 1;
        end
        if (push) begin
            if (sd) begin
                e = model(bv, stk_s); stk_s = e.sticky;
                e.edge_n = last + 2;
                q_s.push_back(e);
            end else begin
                e = model(bv, stk_c); stk_c = e.sticky;
                e.edge_n = last + 2;
                q_c.push_back(e);
            end
        end
    endtask

    // The cycle after the final bit is the evaluation cycle. A valid 1 is
    // presented there and must not be counted.
    task automatic eval_junk(input bit sd);
        @(negedge clk);
        set_in(sd, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle(input bit sd);
        @(negedge clk);
        set_in(sd, 1'b0, 1'b0, 1'b0);
    endtask

    // Scoreboard: pop and compare whenever either instance pulses done.
    always @(negedge clk) begin
        exp_t e;
        if (c_done === 1'b1) begin
            chk("c_done_expected", 32'(q_c.size() > 0), 32'd1);
            if (q_c.size() > 0) begin
                e = q_c.pop_front();
                chk("c_done_edge", cyc,             e.edge_n);
                chk("c_ones_cnt",  32'(c_ones),     32'(e.ones));
                chk("c_runs_cnt",  32'(c_runs_cnt), 32'(e.runs));
                chk("c_err_mono",  32'(c_mono),     32'(e.m));
                chk("c_err_bfreq", 32'(c_bfreq),    32'(e.b));
                chk("c_err_runs",  32'(c_runs),     32'(e.r));
                chk("c_err_sticky",32'(c_sticky),   32'(e.sticky));
            end
        end
        if (s_done === 1'b1) begin
            chk("s_done_expected", 32'(q_s.size() > 0), 32'd1);
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                chk("s_done_edge", cyc,             e.edge_n);
                chk("s_ones_cnt",  32'(s_ones),     32'(e.ones));
                chk("s_runs_cnt",  32'(s_runs_cnt), 32'(e.runs));
                chk("s_err_mono",  32'(s_mono),     32'(e.m));
                chk("s_err_bfreq", 32'(s_bfreq),    32'(e.b));
                chk("s_err_runs",  32'(s_runs),     32'(e.r));
                chk("s_err_sticky",32'(s_sticky),   32'(e.sticky));
            end
        end
    end

    initial begin
        rst = 1'b1;
        c_start = 1'b0; c_valid = 1'b0; c_bit = 1'b0;
        s_start = 1'b0; s_valid = 1'b0; s_bit = 1'b0;
        stk_c = 1'b0; stk_s = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state of both instances
        chk("rst_c_busy",   32'(c_busy),   32'd0);
        chk("rst_c_done",   32'(c_done),   32'd0);
        chk("rst_c_flags",  32'({c_mono, c_bfreq, c_runs, c_sticky}), 32'd0);
        chk("rst_c_ones",   32'(c_ones),   32'd0);
        chk("rst_c_runs",   32'(c_runs_cnt), 32'd0);
        chk("rst_s_busy",   32'(s_busy),   32'd0);
        chk("rst_s_done",   32'(s_done),   32'd0);
        chk("rst_s_flags",  32'({s_mono, s_bfreq, s_runs, s_sticky}), 32'd0);
        chk("rst_s_counts", 32'({s_ones, s_runs_cnt}), 32'd0);

        rst = 1'b0;
        @(negedge clk);
        chk("c_busy_after_rst", 32'(c_busy), 32'd1);
        chk("s_busy_after_rst", 32'(s_busy), 32'd0);

        // Continuous instance: back-to-back sequences
        feed(1'b0, 0, 1'b0, 128, 1'b1, -1); eval_junk(1'b0);   // all zeros
        feed(1'b0, 1, 1'b0, 128, 1'b1, -1); eval_junk(1'b0);   // 0011
        feed(1'b0, 2, 1'b0, 128, 1'b1, 5);  eval_junk(1'b0);   // 0101, stray start
        feed(1'b0, 3, 1'b0, 128, 1'b1, -1); eval_junk(1'b0);   // 8x0 / 8x1
        feed(1'b0, 1, 1'b1, 128, 1'b1, -1); eval_junk(1'b0);   // 0011 with gaps
        feed(1'b0, 2, 1'b0, 128, 1'b1, -1); eval_junk(1'b0);   // checks junk dropped
        idle(1'b0);
        repeat (4) @(negedge clk);

        // Single-shot instance: bits before start are ignored
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_in(1'b1, 1'b1, 1'b1, 1'b0);
        end
        chk("s_idle_busy", 32'(s_busy), 32'd0);
        @(negedge clk);
        set_in(1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        chk("s_busy_after_start", 32'(s_busy), 32'd1);
        feed(1'b1, 1, 1'b0, 128, 1'b1, 40);   // start at bit 40 is ignored
        eval_junk(1'b1);
        idle(1'b1);
        chk("s_idle_after_eval", 32'(s_busy), 32'd0);
        repeat (4) @(negedge clk);

        // Abort mid-collection with reset: no done may follow
        @(negedge clk);
        set_in(1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        feed(1'b1, 3, 1'b0, 60, 1'b0, -1);
        @(negedge clk);
        rst = 1'b1;
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        stk_c = 1'b0; stk_s = 1'b0;
        @(negedge clk);
        chk("abort_s_busy",   32'(s_busy),   32'd0);
        chk("abort_c_sticky", 32'(c_sticky), 32'd0);
        rst = 1'b0;
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        chk("abort_s_busy_idle", 32'(s_busy), 32'd0);

        // Fresh single-shot sequence after the abort
        @(negedge clk);
        set_in(1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        feed(1'b1, 2, 1'b0, 128, 1'b1, -1);
        eval_junk(1'b1);
        idle(1'b1);

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 20 && (q_c.size() + q_s.size()) > 0; k++) @(negedge clk);
        chk("scoreboard_drained", 32'(q_c.size() + q_s.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
